// File: rtl/stego_job_sequencer_pkg.sv
// Shared definitions for the steganography core control/respond register pair:
// control bit positions, finish bit, job status codes and sequencer states.
package stego_job_sequencer_pkg;

    localparam int CTRL_RESETN = 0;
    localparam int CTRL_START  = 1;
    localparam int CTRL_MODE   = 2;
    localparam int CTRL_PSENB  = 3;
    localparam int CTRL_BITS   = 4;

    localparam int RESP_FINISH = 0;

    typedef enum logic [1:0] {
        STATUS_OK       = 2'd0,
        STATUS_TIMEOUT  = 2'd1,
        STATUS_ABORTED  = 2'd2,
        STATUS_BAD_SIZE = 2'd3
    } job_status_t;

    typedef enum logic [2:0] {
        SEQ_IDLE     = 3'd0,
        SEQ_HOLD_RST = 3'd1,
        SEQ_CONFIG   = 3'd2,
        SEQ_START    = 3'd3,
        SEQ_WAIT     = 3'd4,
        SEQ_DONE     = 3'd5
    } seq_state_t;

    // Packs the live control bits; upper register bits are always zero.
    function automatic logic [CTRL_BITS-1:0] ctrl_word(input logic resetn,
                                                       input logic start,
                                                       input logic mode,
                                                       input logic ps_enb);
        logic [CTRL_BITS-1:0] w;
        w = '0;
        w[CTRL_RESETN] = resetn;
        w[CTRL_START]  = start;
        w[CTRL_MODE]   = mode;
        w[CTRL_PSENB]  = ps_enb;
        return w;
    endfunction

endpackage

// File: rtl/stego_job_sequencer_timeout_counter.sv
// Counts enabled cycles since the last clear; expired flags the cycle that is
// the TIMEOUT_CYCLES-th enabled cycle.
module stego_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count_reg <= '0;
        end else if (enable && (count_reg != CNT_LAST)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign expired = enable && (count_reg == CNT_LAST);

endmodule

// File: rtl/stego_job_sequencer.sv
// Turns one job request into the core's reset/config/start/wait control
// sequence and reports completion status with a one-cycle done pulse.
module stego_job_sequencer
    import stego_job_sequencer_pkg::*;
#(
    parameter int                   REG_WIDTH      = 32,
    parameter int                   RST_CYCLES     = 4,
    parameter int                   TIMEOUT_CYCLES = 1000000,
    parameter logic [REG_WIDTH-1:0] MAX_MSG        = REG_WIDTH'(32'h0AAAAAAA)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 job_valid,
    output logic                 job_ready,
    input  logic                 job_mode,
    input  logic                 job_ps_enb,
    input  logic [REG_WIDTH-1:0] job_pic_size,
    input  logic [REG_WIDTH-1:0] job_msg_size,
    input  logic                 abort,
    output logic [REG_WIDTH-1:0] control_signal,
    output logic [REG_WIDTH-1:0] picture_size,
    output logic [REG_WIDTH-1:0] message_size,
    input  logic [REG_WIDTH-1:0] respond_signal,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           status
);

    localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);

    seq_state_t           state_reg;
    job_status_t          status_reg;
    logic [HOLD_W-1:0]    hold_cnt_reg;
    logic [CTRL_BITS-1:0] control_reg;
    logic [REG_WIDTH-1:0] pic_reg;
    logic [REG_WIDTH-1:0] msg_reg;
    logic                 mode_reg;
    logic                 ps_enb_reg;
    logic                 done_reg;
    logic                 abort_active;
    logic                 timeout_expired;
    logic                 unused_resp;

    assign unused_resp = ^respond_signal[REG_WIDTH-1:1];

    assign abort_active = abort && (state_reg != SEQ_IDLE) && (state_reg != SEQ_DONE);

    // Clearing during CONFIG means the count starts from zero as START is entered.
    stego_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state_reg == SEQ_CONFIG),
        .enable (state_reg == SEQ_WAIT),
        .expired(timeout_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= SEQ_IDLE;
            status_reg   <= STATUS_OK;
            hold_cnt_reg <= '0;
            control_reg  <= '0;
            pic_reg      <= '0;
            msg_reg      <= '0;
            mode_reg     <= 1'b0;
            ps_enb_reg   <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (abort_active) begin
                // Dropping reset_n on the DONE cycle resets the core mid-job.
                state_reg   <= SEQ_DONE;
                status_reg  <= STATUS_ABORTED;
                done_reg    <= 1'b1;
                control_reg <= ctrl_word(1'b0, 1'b0, mode_reg, ps_enb_reg);
            end else begin
                case (state_reg)
                    SEQ_IDLE: begin
                        control_reg <= ctrl_word(1'b1, 1'b0, 1'b0, 1'b0);
                        if (job_valid) begin
                            if (job_msg_size > MAX_MSG) begin
                                state_reg   <= SEQ_DONE;
                                status_reg  <= STATUS_BAD_SIZE;
                                done_reg    <= 1'b1;
                                control_reg <= '0;
                            end else begin
                                state_reg    <= SEQ_HOLD_RST;
                                hold_cnt_reg <= '0;
                                mode_reg     <= job_mode;
                                ps_enb_reg   <= job_ps_enb;
                                pic_reg      <= job_pic_size;
                                msg_reg      <= job_msg_size;
                                control_reg  <= ctrl_word(1'b0, 1'b0, job_mode, job_ps_enb);
                            end
                        end
                    end
                    SEQ_HOLD_RST: begin
                        if (hold_cnt_reg == HOLD_LAST) begin
                            state_reg   <= SEQ_CONFIG;
                            control_reg <= ctrl_word(1'b1, 1'b0, mode_reg, ps_enb_reg);
                        end else begin
                            hold_cnt_reg <= hold_cnt_reg + 1'b1;
                        end
                    end
                    SEQ_CONFIG: begin
                        state_reg   <= SEQ_START;
                        control_reg <= ctrl_word(1'b1, 1'b1, mode_reg, ps_enb_reg);
                    end
                    SEQ_START: begin
                        state_reg <= SEQ_WAIT;
                    end
                    SEQ_WAIT: begin
                        // Finish outranks a simultaneous timeout.
                        if (respond_signal[RESP_FINISH]) begin
                            state_reg   <= SEQ_DONE;
                            status_reg  <= STATUS_OK;
                            done_reg    <= 1'b1;
                            control_reg <= ctrl_word(1'b1, 1'b0, mode_reg, ps_enb_reg);
                        end else if (timeout_expired) begin
                            state_reg   <= SEQ_DONE;
                            status_reg  <= STATUS_TIMEOUT;
                            done_reg    <= 1'b1;
                            control_reg <= ctrl_word(1'b1, 1'b0, mode_reg, ps_enb_reg);
                        end
                    end
                    SEQ_DONE: begin
                        state_reg   <= SEQ_IDLE;
                        control_reg <= ctrl_word(1'b1, 1'b0, 1'b0, 1'b0);
                    end
                    default: begin
                        state_reg   <= SEQ_IDLE;
                        control_reg <= '0;
                    end
                endcase
            end
        end
    end

    generate
        for (genvar gi = 0; gi < REG_WIDTH; gi++) begin : g_ctrl
            if (gi < CTRL_BITS) begin : g_live
                assign control_signal[gi] = control_reg[gi];
            end else begin : g_zero
                assign control_signal[gi] = 1'b0;
            end
        end
    endgenerate

    assign picture_size = pic_reg;
    assign message_size = msg_reg;
    assign busy         = (state_reg != SEQ_IDLE);
    assign job_ready    = (state_reg == SEQ_IDLE);
    assign done         = done_reg;
    assign status       = status_reg;

endmodule

// File: tb/tb_stego_job_sequencer.sv
// Directed bench for stego_job_sequencer: control sequencing, finish
// qualification, timeout, abort, size check and mid-job reset.
module tb_stego_job_sequencer;

    logic        clk;
    logic        rst_n;
    logic        job_valid;
    logic        job_ready;
    logic        job_mode;
    logic        job_ps_enb;
    logic [31:0] job_pic_size;
    logic [31:0] job_msg_size;
    logic        abort;
    logic [31:0] control_signal;
    logic [31:0] picture_size;
    logic [31:0] message_size;
    logic [31:0] respond_signal;
    logic        busy;
    logic        done;
    logic [1:0]  status;

    int check_count = 0;
    int pass_count  = 0;

    stego_job_sequencer #(
        .REG_WIDTH     (32),
        .RST_CYCLES    (4),
        .TIMEOUT_CYCLES(8),
        .MAX_MSG       (32'h0AAAAAAA)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .job_valid     (job_valid),
        .job_ready     (job_ready),
        .job_mode      (job_mode),
        .job_ps_enb    (job_ps_enb),
        .job_pic_size  (job_pic_size),
        .job_msg_size  (job_msg_size),
        .abort         (abort),
        .control_signal(control_signal),
        .picture_size  (picture_size),
        .message_size  (message_size),
        .respond_signal(respond_signal),
        .busy          (busy),
        .done          (done),
        .status        (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a job for exactly one acceptance edge; returns in cycle 1 after it.
    task automatic submit(input logic mode, input logic ps, input logic [31:0] pic,
                          input logic [31:0] msg);
        job_mode     = mode;
        job_ps_enb   = ps;
        job_pic_size = pic;
        job_msg_size = msg;
        job_valid    = 1'b1;
        tick();
        job_valid    = 1'b0;
        $display("job submitted mode=%0d ps_enb=%0d pic=%0d msg=%0h", mode, ps, pic, msg);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        check_count++; if (control_signal !== 32'h0) $display("FAIL reset_ctrl got %0h exp 0", control_signal); else pass_count++;
        check_count++; if (picture_size !== 32'h0) $display("FAIL reset_pic got %0h exp 0", picture_size); else pass_count++;
        check_count++; if (message_size !== 32'h0) $display("FAIL reset_msg got %0h exp 0", message_size); else pass_count++;
        check_count++; if ({busy, done, status} !== 4'b0000) $display("FAIL reset_flags got %b exp 0000", {busy, done, status}); else pass_count++;
        check_count++; if (job_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", job_ready); else pass_count++;
        rst_n = 1'b1;
        tick();
        check_count++; if (control_signal !== 32'h1) $display("FAIL idle_ctrl got %0h exp 1", control_signal); else pass_count++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_count++; if ({busy, done} !== 2'b00) $display("FAIL idle_abort got %b exp 00", {busy, done}); else pass_count++;
        $display("reset test complete");
    endtask

    task automatic test_embed();
        logic [31:0] exp_ctrl;
        submit(1'b0, 1'b0, 32'd100, 32'd10);
        for (int i = 1; i <= 11; i++) begin
            exp_ctrl = (i <= 4) ? 32'h0 : ((i == 5) ? 32'h1 : 32'h3);
            check_count++; if (control_signal !== exp_ctrl) $display("FAIL embed_ctrl cycle %0d got %0h exp %0h", i, control_signal, exp_ctrl); else pass_count++;
            check_count++; if (done !== 1'b0) $display("FAIL embed_early_done cycle %0d got %b exp 0", i, done); else pass_count++;
            if (i == 11) respond_signal = 32'h1;
            tick();
        end
        check_count++; if (done !== 1'b1) $display("FAIL embed_done got %b exp 1", done); else pass_count++;
        check_count++; if (status !== 2'd0) $display("FAIL embed_status got %0d exp 0", status); else pass_count++;
        check_count++; if (control_signal[1] !== 1'b0) $display("FAIL embed_done_start got %b exp 0", control_signal[1]); else pass_count++;
        check_count++; if ({busy, job_ready} !== 2'b10) $display("FAIL embed_done_busy got %b exp 10", {busy, job_ready}); else pass_count++;
        respond_signal = 32'h0;
        tick();
        check_count++; if ({busy, done, job_ready} !== 3'b001) $display("FAIL embed_idle got %b exp 001", {busy, done, job_ready}); else pass_count++;
        check_count++; if (control_signal !== 32'h1) $display("FAIL embed_idle_ctrl got %0h exp 1", control_signal); else pass_count++;
        check_count++; if ({picture_size, message_size} !== {32'd100, 32'd10}) $display("FAIL embed_sizes got %0d/%0d exp 100/10", picture_size, message_size); else pass_count++;
        $display("embed job done");
    endtask

    task automatic test_extract();
        logic [31:0] exp_ctrl;
        submit(1'b1, 1'b1, 32'd200, 32'd20);
        for (int i = 1; i <= 7; i++) begin
            exp_ctrl = (i <= 4) ? 32'hC : ((i == 5) ? 32'hD : 32'hF);
            check_count++; if (control_signal !== exp_ctrl) $display("FAIL extract_ctrl cycle %0d got %0h exp %0h", i, control_signal, exp_ctrl); else pass_count++;
            if (i == 7) respond_signal = 32'h1;
            tick();
        end
        respond_signal = 32'h0;
        check_count++; if ({done, status} !== 3'b100) $display("FAIL extract_done got %b exp 100", {done, status}); else pass_count++;
        tick();
        $display("extract job done");
    endtask

    task automatic test_stale_finish();
        int cnt;
        respond_signal = 32'h1;
        submit(1'b0, 1'b1, 32'd50, 32'd5);
        cnt = 1;
        while (!done && cnt < 20) begin
            tick();
            cnt++;
        end
        check_count++; if (cnt !== 8) $display("FAIL stale_latency got %0d exp 8", cnt); else pass_count++;
        check_count++; if (status !== 2'd0) $display("FAIL stale_status got %0d exp 0", status); else pass_count++;
        respond_signal = 32'h0;
        tick();
        $display("stale finish job done latency=%0d", cnt);
    endtask

    task automatic test_timeout();
        int cnt;
        submit(1'b0, 1'b0, 32'd5, 32'd5);
        cnt = 1;
        while (!done && cnt < 40) begin
            tick();
            cnt++;
        end
        check_count++; if (cnt !== 15) $display("FAIL timeout_latency got %0d exp 15", cnt); else pass_count++;
        check_count++; if (status !== 2'd1) $display("FAIL timeout_status got %0d exp 1", status); else pass_count++;
        job_mode = 1'b0; job_ps_enb = 1'b0; job_pic_size = 32'd7; job_msg_size = 32'd7;
        job_valid = 1'b1;
        tick();
        check_count++; if (job_ready !== 1'b1) $display("FAIL timeout_ready got %b exp 1", job_ready); else pass_count++;
        tick();
        job_valid = 1'b0;
        check_count++; if ({busy, control_signal} !== {1'b1, 32'h0}) $display("FAIL timeout_next_accept got busy=%b ctrl=%0h exp busy=1 ctrl=0", busy, control_signal); else pass_count++;
        check_count++; if (picture_size !== 32'd7) $display("FAIL timeout_next_pic got %0d exp 7", picture_size); else pass_count++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_count++; if ({done, status, control_signal[0]} !== 4'b1100) $display("FAIL hold_abort got %b exp 1100", {done, status, control_signal[0]}); else pass_count++;
        tick();
        $display("timeout job done latency=%0d, follow-up job aborted in hold", cnt);
    endtask

    task automatic test_abort_finish();
        submit(1'b0, 1'b0, 32'd300, 32'd30);
        for (int i = 1; i <= 6; i++) tick();
        abort = 1'b1;
        respond_signal = 32'h1;
        tick();
        abort = 1'b0;
        respond_signal = 32'h0;
        check_count++; if ({done, status} !== 3'b110) $display("FAIL abort_status got %b exp 110", {done, status}); else pass_count++;
        check_count++; if (control_signal[0] !== 1'b0) $display("FAIL abort_resetn got %b exp 0", control_signal[0]); else pass_count++;
        tick();
        $display("abort+finish job done");
    endtask

    task automatic test_bad_size();
        submit(1'b1, 1'b1, 32'd999, 32'h0AAAAAAB);
        check_count++; if ({done, status} !== 3'b111) $display("FAIL badsize_status got %b exp 111", {done, status}); else pass_count++;
        check_count++; if (control_signal !== 32'h0) $display("FAIL badsize_ctrl got %0h exp 0", control_signal); else pass_count++;
        check_count++; if ({picture_size, message_size} !== {32'd300, 32'd30}) $display("FAIL badsize_sizes got %0d/%0d exp 300/30", picture_size, message_size); else pass_count++;
        tick();
        check_count++; if ({busy, done} !== 2'b00) $display("FAIL badsize_idle got %b exp 00", {busy, done}); else pass_count++;
        submit(1'b0, 1'b0, 32'd1, 32'h0AAAAAAA);
        check_count++; if ({busy, done, message_size} !== {2'b10, 32'h0AAAAAAA}) $display("FAIL maxmsg_accept got busy=%b done=%b msg=%0h exp 1 0 aaaaaaa", busy, done, message_size); else pass_count++;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        $display("bad size and max size jobs done");
    endtask

    task automatic test_reset_mid_wait();
        submit(1'b1, 1'b0, 32'd400, 32'd40);
        for (int i = 1; i <= 6; i++) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_count++; if ({control_signal, picture_size, message_size} !== 96'h0) $display("FAIL midreset_regs got %0h/%0h/%0h exp 0/0/0", control_signal, picture_size, message_size); else pass_count++;
        check_count++; if ({busy, done, status, job_ready} !== 5'b00001) $display("FAIL midreset_flags got %b exp 00001", {busy, done, status, job_ready}); else pass_count++;
        tick();
        check_count++; if ({done, control_signal} !== {1'b0, 32'h1}) $display("FAIL midreset_after got done=%b ctrl=%0h exp 0 1", done, control_signal); else pass_count++;
        $display("reset mid-wait done");
    endtask

    initial begin
        rst_n          = 1'b0;
        job_valid      = 1'b0;
        job_mode       = 1'b0;
        job_ps_enb     = 1'b0;
        job_pic_size   = 32'h0;
        job_msg_size   = 32'h0;
        abort          = 1'b0;
        respond_signal = 32'h0;
        test_reset();
        test_embed();
        test_extract();
        test_stale_finish();
        test_timeout();
        test_abort_finish();
        test_bad_size();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
